// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction requests into 32-bit words, queues them in a small FIFO and streams
// them into IMEM at incrementing addresses. Optional `ENC_CHECKSUM_EN adds an XOR checksum output.
module instr_encoder_loader #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [3:0]        rd,
  input  logic [3:0]        rs1,
  input  logic [3:0]        rs2,
  input  logic [11:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
`ifdef ENC_CHECKSUM_EN
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
`else
  output logic [ADDR_W:0]   word_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state;
  logic [31:0]        mem [DEPTH];
  logic [PTR_W:0]     wr_ptr, rd_ptr;
  logic               err_ovf;
  logic               empty, full, accept, push, pop, last_addr;
  logic [4:0]         opcode;
  logic [2:0]         typ;
  logic               use_imm, illegal;
  logic [31:0]        enc_word;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    opcode  = 5'b00000;
    typ     = 3'b000;
    use_imm = 1'b0;
    illegal = 1'b0;
    case (op_sel)
      4'd0:    begin opcode = 5'b11000; use_imm = 1'b1; end
      4'd1:    opcode = 5'b10101;
      4'd2:    opcode = 5'b11011;
      4'd3:    opcode = 5'b11111;
      4'd4:    opcode = 5'b11110;
      4'd5:    opcode = 5'b01100;
      4'd6:    begin opcode = 5'b10001; typ = 3'b111; end
      4'd7:    begin opcode = 5'b10010; typ = 3'b100; use_imm = 1'b1; end
      4'd8:    begin opcode = 5'b00001; typ = 3'b111; end
      4'd9:    begin opcode = 5'b11111; typ = 3'b111; end
      4'd10:   begin opcode = 5'b11100; typ = 3'b111; end
      4'd11:   begin opcode = 5'b10110; typ = 3'b100; end
      4'd12:   begin opcode = 5'b11011; typ = 3'b010; end
      4'd13:   begin opcode = 5'b10111; typ = 3'b100; use_imm = 1'b1; end
      4'd14:   begin opcode = 5'b11011; typ = 3'b110; use_imm = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

  assign enc_word = {opcode, typ, rd, rs1, rs2, (use_imm ? imm : 12'h000)};

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign in_ready  = (state == S_RUN) && !full && !err_ovf;
  assign accept    = in_valid && in_ready;
  assign push      = accept && !illegal;
  assign imem_we   = busy && !empty;
  assign pop       = imem_we && imem_ready;
  assign last_addr = (imem_addr == {ADDR_W{1'b1}});
  assign imem_wdata = empty ? 32'h0 : mem[rd_ptr[PTR_W-1:0]];

  // NOTE: FIFO storage carries no reset; validity comes from the reset pointers and the empty gate above.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= enc_word;
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in this block
  // deliberately override earlier ones (start flush, overflow abort).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      imem_addr  <= '0;
      word_count <= '0;
      err        <= 1'b0;
      err_ovf    <= 1'b0;
      done       <= 1'b0;
`ifdef ENC_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (accept && illegal) err <= 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + (PTR_W+1)'(1);
        imem_addr  <= imem_addr + ADDR_W'(1);
        word_count <= word_count + (ADDR_W+1)'(1);
`ifdef ENC_CHECKSUM_EN
        checksum   <= checksum ^ imem_wdata;
`endif
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            imem_addr  <= base_addr;
            word_count <= '0;
            err        <= 1'b0;
            err_ovf    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
`ifdef ENC_CHECKSUM_EN
            checksum   <= '0;
`endif
          end
        end
        S_RUN: begin
          if (finish) begin
            if (empty && !push) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (empty) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Writing the top IMEM word ends the load: remaining queued words are dropped.
      if (pop && last_addr) begin
        err     <= 1'b1;
        err_ovf <= 1'b1;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        state   <= S_DONE;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed scenarios plus randomized requests,
// checked against a table-driven encoder model and a queue scoreboard of expected IMEM writes.
module tb_instr_encoder_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;

  // Opcode / type-bit tables indexed by op_sel (entry 15 unused: illegal).
  localparam logic [4:0] OPC [0:15] = '{5'b11000, 5'b10101, 5'b11011, 5'b11111, 5'b11110, 5'b01100,
                                        5'b10001, 5'b10010, 5'b00001, 5'b11111, 5'b11100, 5'b10110,
                                        5'b11011, 5'b10111, 5'b11011, 5'b00000};
  localparam logic [2:0] TYP [0:15] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                        3'b111, 3'b100, 3'b111, 3'b111, 3'b111, 3'b100,
                                        3'b010, 3'b100, 3'b110, 3'b000};

  logic              clk = 1'b0;
  logic              rst_n, start, finish, in_valid, in_ready, imem_we, imem_ready, busy, done, err;
  logic [ADDR_W-1:0] base_addr, imem_addr;
  logic [3:0]        op_sel, rd, rs1, rs2;
  logic [11:0]       imm;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  int                n_cmp = 0;
  int                n_err = 0;
  logic [31:0]       exp_q [$];
  logic [31:0]       wr_log [$];
  logic [31:0]       mon_exp;
  logic [ADDR_W-1:0] exp_addr;
  int                wcnt;
  logic [31:0]       exp_csum;
  logic              exp_err;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .busy(busy), .done(done), .err(err),
`ifdef ENC_CHECKSUM_EN
    .word_count(word_count), .checksum(checksum)
`else
    .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] encode(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s1,
                                         input logic [3:0] s2, input logic [11:0] im);
    logic [11:0] f;
    f = (op == 4'd0 || op == 4'd7 || op == 4'd13 || op == 4'd14) ? im : 12'h000;
    return {OPC[op], TYP[op], d, s1, s2, f};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every committed IMEM write must match the oldest expected word and address.
  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1 && imem_we === 1'b1 && imem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(imem_we), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("wdata", 64'(imem_wdata), 64'(mon_exp));
        check("waddr", 64'(imem_addr), 64'(exp_addr));
        wr_log.push_back(imem_wdata);
        exp_csum = exp_csum ^ mon_exp;
        wcnt++;
        if (exp_addr == {ADDR_W{1'b1}}) exp_q.delete();
        exp_addr = exp_addr + 1'b1;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_imem_we"}, 64'(imem_we), 64'd0);
    check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_word_count"}, 64'(word_count), 64'd0);
`ifdef ENC_CHECKSUM_EN
    check({tag, "_checksum"}, 64'(checksum), 64'd0);
`endif
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    exp_addr = base;
    wcnt = 0;
    exp_csum = 32'h0;
    exp_err = 1'b0;
    wr_log.delete();
    check("start_busy", 64'(busy), 64'd1);
    check("start_addr", 64'(imem_addr), 64'(base));
    check("start_wc", 64'(word_count), 64'd0);
    check("start_err", 64'(err), 64'd0);
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s1,
                      input logic [3:0] s2, input logic [11:0] im, input bit rnd_ready);
    int t;
    t = 0;
    @(negedge clk);
    op_sel = op; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    if (rnd_ready) imem_ready = ($urandom_range(0, 3) != 0);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
      if (rnd_ready) imem_ready = ($urandom_range(0, 3) != 0);
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    else if (op != 4'd15) exp_q.push_back(encode(op, d, s1, s2, im));
    else exp_err = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic finish_req();
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_word_count"}, 64'(word_count), 64'(wcnt));
    check({tag, "_addr"}, 64'(imem_addr), 64'(exp_addr));
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
`ifdef ENC_CHECKSUM_EN
    check({tag, "_checksum"}, 64'(checksum), 64'(exp_csum));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] o;
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0; base_addr = '0;
    op_sel = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; imem_ready = 1'b1;
    exp_addr = '0; wcnt = 0; exp_csum = 32'h0; exp_err = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single ADD word at base 0x10.
    do_start(8'h10);
    send(4'd1, 4'd1, 4'd2, 4'd3, 12'h000, 1'b0);
    finish_req();
    wait_done("add");
    check("add_word", 64'(wr_log[0]), 64'h0000_0000_A812_3000);

    // MUL vs VMUL differ only in the type bits; MOVI carries its immediate.
    do_start(8'h18);
    send(4'd3, 4'd4, 4'd5, 4'd6, 12'hFFF, 1'b0);
    send(4'd9, 4'd4, 4'd5, 4'd6, 12'hFFF, 1'b0);
    send(4'd0, 4'd7, 4'd0, 4'd0, 12'hABC, 1'b0);
    finish_req();
    wait_done("mul");
    check("mul_vmul_diff", 64'(wr_log[0] ^ wr_log[1]), 64'h0000_0000_0700_0000);
    check("movi_imm", 64'(wr_log[2][11:0]), 64'h0ABC);

    // Illegal op: nothing enqueued, err sticky until the next start.
    do_start(8'h30);
    send(4'd15, 4'd1, 4'd1, 4'd1, 12'h123, 1'b0);
    @(negedge clk);
    check("illegal_err", 64'(err), 64'd1);
    check("illegal_no_we", 64'(imem_we), 64'd0);
    finish_req();
    wait_done("illegal");
    check("illegal_err_after", 64'(err), 64'd1);
    do_start(8'h30);
    finish_req();
    wait_done("restart");

    // IMEM stalled: FIFO fills after DEPTH words, head held steady, then all drain in order.
    imem_ready = 1'b0;
    do_start(8'h20);
    for (int i = 0; i < 4; i++) begin
      o = 4'($urandom_range(0, 14));
      send(o, 4'($urandom), 4'($urandom), 4'($urandom), 12'($urandom), 1'b0);
    end
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 10; i++) begin
      check("stall_we", 64'(imem_we), 64'd1);
      check("stall_data", 64'(imem_wdata), 64'(exp_q[0]));
      check("stall_addr", 64'(imem_addr), 64'(exp_addr));
      @(negedge clk);
    end
    imem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      o = 4'($urandom_range(0, 14));
      send(o, 4'($urandom), 4'($urandom), 4'($urandom), 12'($urandom), 1'b0);
    end
    finish_req();
    wait_done("stall");
    check("stall_count", 64'(wcnt), 64'd6);

    // Randomized requests with random IMEM back-pressure.
    do_start(8'h40);
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      send(o, 4'($urandom), 4'($urandom), 4'($urandom), 12'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    imem_ready = 1'b1;
    finish_req();
    wait_done("random");
    check("random_err", 64'(err), 64'(exp_err));

    // Address overflow: words land at 0xFE and 0xFF, the third is dropped.
    imem_ready = 1'b0;
    do_start(8'hFE);
    for (int i = 0; i < 3; i++) send(4'(i + 1), 4'(i), 4'(i), 4'(i), 12'h000, 1'b0);
    @(negedge clk);
    imem_ready = 1'b1;
    wait_done("overflow");
    check("overflow_err", 64'(err), 64'd1);
    check("overflow_count", 64'(wcnt), 64'd2);
    check("overflow_in_ready", 64'(in_ready), 64'd0);
    check("overflow_we", 64'(imem_we), 64'd0);

    // Asynchronous reset while draining.
    imem_ready = 1'b0;
    do_start(8'h80);
    for (int i = 0; i < 3; i++) send(4'd2, 4'(i), 4'd1, 4'd2, 12'h000, 1'b0);
    finish_req();
    check("drain_busy", 64'(busy), 64'd1);
    check("drain_in_ready", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_drain");
    exp_q.delete();
    exp_addr = '0;
    wcnt = 0;
    exp_csum = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_we", 64'(imem_we), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
